// File: rtl/penalty_monitor_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : penalty_monitor_multi_if
// Brief    : Sensor/billing-side bundle for the multi-lane penalty monitor.
//            viol_cnt exists only when PSYS_VIOL_CNT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface penalty_monitor_multi_if #(
    parameter int NUM_LANES = 4,
    parameter int SEC_W     = 4
`ifdef PSYS_VIOL_CNT_EN
   ,parameter int CNT_W     = 8
`endif
);
    logic                       tick;
    logic [NUM_LANES-1:0]       red;
    logic [NUM_LANES-1:0]       ack;
    logic [SEC_W-1:0]           limit;
    logic [NUM_LANES*SEC_W-1:0] sec;
    logic [NUM_LANES-1:0]       penalty;
    logic                       any_penalty;
`ifdef PSYS_VIOL_CNT_EN
    logic [NUM_LANES*CNT_W-1:0] viol_cnt;
`endif

    modport master (
        output tick, red, ack, limit,
        input  sec, penalty, any_penalty
`ifdef PSYS_VIOL_CNT_EN
       ,input  viol_cnt
`endif
    );

    modport slave (
        input  tick, red, ack, limit,
        output sec, penalty, any_penalty
`ifdef PSYS_VIOL_CNT_EN
       ,output viol_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/penalty_monitor_multi.sv
`default_nettype none
// ============================================================================
// Module   : penalty_monitor_multi
// Brief    : NUM_LANES independent red-time penalty timers on a shared 1 Hz
//            tick with sticky, software-acknowledged penalty flags.
//            Optional macro PSYS_VIOL_CNT_EN adds saturating violation counts.
// Revision : 1.0  initial release
// ============================================================================
module penalty_monitor_multi #(
    parameter int NUM_LANES = 4,
    parameter int SEC_W     = 4
`ifdef PSYS_VIOL_CNT_EN
   ,parameter int CNT_W     = 8
`endif
) (
    input  wire                    clk,
    input  wire                    reset,
    penalty_monitor_multi_if.slave bus
);
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_TIMING  = 2'd1;
    localparam logic [1:0] c_PENALTY = 2'd2;
    localparam logic [1:0] c_HOLD    = 2'd3;

    logic [NUM_LANES*SEC_W-1:0] w_sec;
    logic [NUM_LANES-1:0]       w_penalty;
    logic                       r_any_penalty;
`ifdef PSYS_VIOL_CNT_EN
    logic [NUM_LANES*CNT_W-1:0] w_viol_cnt;
`endif

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic [1:0]       r_state;
        logic [1:0]       w_state_nxt;
        logic [SEC_W-1:0] r_sec;
        logic [SEC_W-1:0] w_sec_nxt;
        logic             w_red;
        logic             w_ack;

        assign w_red = bus.red[gi];
        assign w_ack = bus.ack[gi];

        // sec can only advance while below limit, so it never wraps
        always_comb begin
            w_state_nxt = r_state;
            w_sec_nxt   = r_sec;
            case (r_state)
                c_IDLE: begin
                    w_sec_nxt = '0;
                    if (w_red) w_state_nxt = c_TIMING;
                end
                c_TIMING: begin
                    if (!w_red) begin
                        w_state_nxt = c_IDLE;
                        w_sec_nxt   = '0;
                    end else if (bus.tick) begin
                        if (r_sec >= bus.limit) w_state_nxt = c_PENALTY;
                        else                    w_sec_nxt   = r_sec + SEC_W'(1);
                    end
                end
                c_PENALTY: begin
                    if (!w_red) w_state_nxt = c_HOLD;
                end
                c_HOLD: begin
                    if (w_ack) begin
                        w_state_nxt = c_IDLE;
                        w_sec_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                    w_sec_nxt   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_state <= c_IDLE;
                r_sec   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_sec   <= w_sec_nxt;
            end
        end

        assign w_sec[gi*SEC_W +: SEC_W] = r_sec;
        assign w_penalty[gi]            = (r_state == c_PENALTY) || (r_state == c_HOLD);

`ifdef PSYS_VIOL_CNT_EN
        logic [CNT_W-1:0] r_viol;
        logic             w_pen_entry;

        assign w_pen_entry = (r_state == c_TIMING) && (w_state_nxt == c_PENALTY);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_viol <= '0;
            end else if (w_pen_entry && (r_viol != {CNT_W{1'b1}})) begin
                r_viol <= r_viol + CNT_W'(1);
            end
        end

        assign w_viol_cnt[gi*CNT_W +: CNT_W] = r_viol;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_any_penalty <= 1'b0;
        else        r_any_penalty <= |w_penalty;
    end

    assign bus.sec         = w_sec;
    assign bus.penalty     = w_penalty;
    assign bus.any_penalty = r_any_penalty;
`ifdef PSYS_VIOL_CNT_EN
    assign bus.viol_cnt    = w_viol_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_penalty_monitor_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_penalty_monitor_multi
// Brief    : Directed vector table, corner sequences and a randomized run
//            against a rule-level reference model of the penalty monitor.
// Revision : 1.0  initial release
// ============================================================================
module tb_penalty_monitor_multi;
    localparam int NL = 4;
    localparam int SW = 4;
`ifdef PSYS_VIOL_CNT_EN
    localparam int CW = 2;
`endif

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_err    = 0;

`ifdef PSYS_VIOL_CNT_EN
    penalty_monitor_multi_if #(.NUM_LANES(NL), .SEC_W(SW), .CNT_W(CW)) bus ();
    penalty_monitor_multi #(.NUM_LANES(NL), .SEC_W(SW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus));
`else
    penalty_monitor_multi_if #(.NUM_LANES(NL), .SEC_W(SW)) bus ();
    penalty_monitor_multi #(.NUM_LANES(NL), .SEC_W(SW)) dut (
        .clk(clk), .reset(reset), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [NL-1:0] red, input logic [NL-1:0] ack,
                        input logic tick, input logic [SW-1:0] lim);
        bus.red   = red;
        bus.ack   = ack;
        bus.tick  = tick;
        bus.limit = lim;
        @(posedge clk);
        #1;
    endtask

    // ---------------- rule-level reference model ----------------
    bit m_counting [NL];
    bit m_flag     [NL];
    bit m_released [NL];
    int m_secs     [NL];
    int m_viols    [NL];
    bit m_any;

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_counting[i] = 0; m_flag[i] = 0; m_released[i] = 0;
            m_secs[i] = 0; m_viols[i] = 0;
        end
        m_any = 0;
    endtask

    task automatic model_step(input logic [NL-1:0] red, input logic [NL-1:0] ack,
                              input logic tick, input int lim);
        bit any_now;
        any_now = 0;
        for (int i = 0; i < NL; i++) any_now |= m_flag[i];
        m_any = any_now;
        for (int i = 0; i < NL; i++) begin
            if (m_flag[i]) begin
                if (m_released[i] && ack[i]) begin
                    m_flag[i] = 0; m_secs[i] = 0; m_counting[i] = 0;
                end else if (!red[i]) begin
                    m_released[i] = 1;
                end
            end else if (m_counting[i]) begin
                if (!red[i]) begin
                    m_counting[i] = 0; m_secs[i] = 0;
                end else if (tick) begin
                    if (m_secs[i] >= lim) begin
                        m_flag[i] = 1; m_released[i] = 0; m_counting[i] = 0;
                        m_viols[i]++;
                    end else begin
                        m_secs[i]++;
                    end
                end
            end else if (red[i]) begin
                m_counting[i] = 1;
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [NL-1:0]    red;
        logic [NL-1:0]    ack;
        logic             tick;
        logic [SW-1:0]    limit;
        logic [NL*SW-1:0] e_sec;
        logic [NL-1:0]    e_pen;
        logic             e_any;
    } vec_t;

    vec_t tbl [25];

    initial begin
        logic [NL-1:0]    r_red;
        logic [NL-1:0]    r_ack;
        logic             r_tick;
        logic [SW-1:0]    r_lim;
        logic [NL*SW-1:0] e_sec;
        logic [NL-1:0]    e_pen;

        tbl[0]  = '{4'b0000, 4'b0000, 1'b1, 4'd5, 16'h0000, 4'b0000, 1'b0};
        tbl[1]  = '{4'b0001, 4'b0000, 1'b0, 4'd5, 16'h0000, 4'b0000, 1'b0};
        tbl[2]  = '{4'b0001, 4'b0000, 1'b1, 4'd5, 16'h0001, 4'b0000, 1'b0};
        tbl[3]  = '{4'b0001, 4'b0000, 1'b1, 4'd5, 16'h0002, 4'b0000, 1'b0};
        tbl[4]  = '{4'b0001, 4'b0000, 1'b0, 4'd5, 16'h0002, 4'b0000, 1'b0};
        tbl[5]  = '{4'b0001, 4'b0000, 1'b1, 4'd5, 16'h0003, 4'b0000, 1'b0};
        tbl[6]  = '{4'b0001, 4'b0000, 1'b1, 4'd5, 16'h0004, 4'b0000, 1'b0};
        tbl[7]  = '{4'b0001, 4'b0000, 1'b1, 4'd5, 16'h0005, 4'b0000, 1'b0};
        tbl[8]  = '{4'b0001, 4'b0000, 1'b1, 4'd5, 16'h0005, 4'b0001, 1'b0};
        tbl[9]  = '{4'b0001, 4'b0001, 1'b0, 4'd5, 16'h0005, 4'b0001, 1'b1};
        tbl[10] = '{4'b0000, 4'b0000, 1'b0, 4'd5, 16'h0005, 4'b0001, 1'b1};
        tbl[11] = '{4'b0001, 4'b0000, 1'b1, 4'd5, 16'h0005, 4'b0001, 1'b1};
        tbl[12] = '{4'b0001, 4'b0001, 1'b0, 4'd5, 16'h0000, 4'b0000, 1'b1};
        tbl[13] = '{4'b0001, 4'b0000, 1'b1, 4'd5, 16'h0000, 4'b0000, 1'b0};
        tbl[14] = '{4'b0000, 4'b0000, 1'b0, 4'd5, 16'h0000, 4'b0000, 1'b0};
        tbl[15] = '{4'b0010, 4'b0000, 1'b0, 4'd5, 16'h0000, 4'b0000, 1'b0};
        tbl[16] = '{4'b0010, 4'b0000, 1'b1, 4'd5, 16'h0010, 4'b0000, 1'b0};
        tbl[17] = '{4'b0010, 4'b0000, 1'b1, 4'd5, 16'h0020, 4'b0000, 1'b0};
        tbl[18] = '{4'b0010, 4'b0000, 1'b1, 4'd5, 16'h0030, 4'b0000, 1'b0};
        tbl[19] = '{4'b0000, 4'b0000, 1'b1, 4'd5, 16'h0000, 4'b0000, 1'b0};
        tbl[20] = '{4'b0010, 4'b0000, 1'b0, 4'd5, 16'h0000, 4'b0000, 1'b0};
        tbl[21] = '{4'b0010, 4'b0000, 1'b1, 4'd5, 16'h0010, 4'b0000, 1'b0};
        tbl[22] = '{4'b0010, 4'b0000, 1'b1, 4'd0, 16'h0010, 4'b0010, 1'b0};
        tbl[23] = '{4'b1010, 4'b0000, 1'b1, 4'd0, 16'h0010, 4'b0010, 1'b1};
        tbl[24] = '{4'b1010, 4'b0000, 1'b1, 4'd0, 16'h0010, 4'b1010, 1'b1};

        reset     = 1'b0;
        bus.red   = '0;
        bus.ack   = '0;
        bus.tick  = 1'b0;
        bus.limit = 4'd5;
        repeat (2) @(posedge clk);
        #1;
        check("reset_sec", bus.sec, 0);
        check("reset_penalty", bus.penalty, 0);
        check("reset_any", bus.any_penalty, 0);
        reset = 1'b1;

        // idle lanes must ignore ticks entirely
        for (int i = 0; i < 10; i++) step(4'b0000, 4'b0000, 1'b1, 4'd5);
        check("idle_sec", bus.sec, 0);
        check("idle_penalty", bus.penalty, 0);
        check("idle_any", bus.any_penalty, 0);

        for (int v = 0; v < 25; v++) begin
            step(tbl[v].red, tbl[v].ack, tbl[v].tick, tbl[v].limit);
            check($sformatf("tbl%0d_sec", v), bus.sec, tbl[v].e_sec);
            check($sformatf("tbl%0d_pen", v), bus.penalty, tbl[v].e_pen);
            check($sformatf("tbl%0d_any", v), bus.any_penalty, tbl[v].e_any);
        end

        // lane 3 re-violates three more times with limit 0
        for (int k = 0; k < 3; k++) begin
            step(4'b0010, 4'b0000, 1'b0, 4'd0);
            check("l3_hold_pen", bus.penalty[3], 1);
            step(4'b0010, 4'b1000, 1'b0, 4'd0);
            check("l3_ack_pen", bus.penalty[3], 0);
            step(4'b1010, 4'b0000, 1'b0, 4'd0);
            step(4'b1010, 4'b0000, 1'b1, 4'd0);
            check("l3_first_tick_pen", bus.penalty[3], 1);
        end
`ifdef PSYS_VIOL_CNT_EN
        check("l3_viol_sat", bus.viol_cnt[3*CW +: CW], 3);
        check("l1_viol", bus.viol_cnt[1*CW +: CW], 1);
`endif

        // lane 2 with maximum limit: sec saturates at all-ones then penalises
        step(4'b1110, 4'b0000, 1'b0, 4'd15);
        for (int t = 0; t < 15; t++) step(4'b1110, 4'b0000, 1'b1, 4'd15);
        check("l2_sec_max", bus.sec[11:8], 15);
        check("l2_pen_before", bus.penalty[2], 0);
        step(4'b1110, 4'b0000, 1'b1, 4'd15);
        check("l2_sec_hold", bus.sec[11:8], 15);
        check("l2_pen_after", bus.penalty[2], 1);

        // lane 0 into HOLD, then asynchronous reset between edges
        step(4'b1111, 4'b0000, 1'b0, 4'd0);
        step(4'b1111, 4'b0000, 1'b1, 4'd0);
        step(4'b1110, 4'b0000, 1'b0, 4'd0);
        check("l0_hold_pen", bus.penalty[0], 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_sec", bus.sec, 0);
        check("async_pen", bus.penalty, 0);
        check("async_any", bus.any_penalty, 0);
`ifdef PSYS_VIOL_CNT_EN
        check("async_viol", bus.viol_cnt, 0);
`endif
        step(4'b0000, 4'b0000, 1'b0, 4'd0);
        reset = 1'b1;

        // randomized run against the reference model
        model_reset();
        r_red = '0;
        r_lim = 4'd3;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NL; i++)
                if ($urandom_range(0, 5) == 0) r_red[i] = ~r_red[i];
            r_ack  = NL'($urandom_range(0, 15) & $urandom_range(0, 15));
            r_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0)
                r_lim = ($urandom_range(0, 9) == 0) ? 4'd15 : SW'($urandom_range(0, 6));
            step(r_red, r_ack, r_tick, r_lim);
            model_step(r_red, r_ack, r_tick, int'(r_lim));
            for (int i = 0; i < NL; i++) begin
                e_sec[i*SW +: SW] = SW'(m_secs[i]);
                e_pen[i]          = m_flag[i];
            end
            check("rnd_sec", bus.sec, e_sec);
            check("rnd_pen", bus.penalty, e_pen);
            check("rnd_any", bus.any_penalty, m_any);
`ifdef PSYS_VIOL_CNT_EN
            for (int i = 0; i < NL; i++)
                check("rnd_viol", bus.viol_cnt[i*CW +: CW],
                      (m_viols[i] > 3) ? 3 : m_viols[i]);
`endif
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
